clock_gen_multi: RTL and testbench

Multi-channel, runtime-configurable tick/clock-enable generator. It is the parametrised successor to the single-channel `ClockGen` divider used at the MIPS top level. One instance replaces several fixed dividers (heartbeat LED, sampling strobes, UART bit-rate enables). It provides a per-channel terminal count, per-channel mode (toggle, pulse, one-shot) and per-channel gating. All outputs are registered and synchronous to the system clock.

---
 rtl/clock_gen_multi.sv | 128 ++++++++++++
 tb/tb_clock_gen_multi.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_gen_multi.sv
// clock_gen_multi: multi-channel runtime-configurable tick / clock-enable generator.
// Each channel divides the system clock by a programmable terminal count and
// drives a registered tick strobe plus a mode-dependent flag (toggle, pulse,
// one-shot). Configuration writes re-arm a channel and override counting.
module clock_gen_multi #(
    parameter int                   CHANNELS     = 4,
    parameter int                   CH_SEL_WIDTH = 2,
    parameter int                   CNT_WIDTH    = 32,
    parameter logic [CNT_WIDTH-1:0] DEFAULT_MAX  = CNT_WIDTH'(50000000)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [CHANNELS-1:0]     ch_enable,
    input  logic                    cfg_we,
    input  logic [CH_SEL_WIDTH-1:0] cfg_ch,
    input  logic [CNT_WIDTH-1:0]    cfg_max,
    input  logic [1:0]              cfg_mode,
    output logic [CHANNELS-1:0]     flag,
    output logic [CHANNELS-1:0]     tick,
    output logic [CHANNELS-1:0]     done
);

    typedef enum logic [1:0] {
        MODE_TOGGLE  = 2'b00,
        MODE_PULSE   = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11   // behaves as pulse
    } mode_e;

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] max_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] max_d    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_q    [CHANNELS];
    logic [CNT_WIDTH-1:0] cnt_d    [CHANNELS];
    logic [CNT_WIDTH-1:0] last_cnt [CHANNELS];
    mode_e                mode_q   [CHANNELS];
    mode_e                mode_d   [CHANNELS];

    logic [CHANNELS-1:0] flag_q, flag_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] done_q, done_d;
    logic [CHANNELS-1:0] counting;
    logic [CHANNELS-1:0] cfg_hit;

    // A halted one-shot channel stops counting until it is re-armed.
    assign counting = {CHANNELS{enable}} & ch_enable & ~done_q;

    // Terminal counter value (M_eff - 1); a programmed 0 behaves like 1, so both end at 0.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            last_cnt[i] = (max_q[i] == '0) ? '0 : max_q[i] - ONE;
        end
    end

    // Decode the configuration write; indices beyond the last channel match nothing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cfg_hit[i] = cfg_we && (cfg_ch == CH_SEL_WIDTH'(i));
        end
    end

    // Per-channel next state: configuration write first, then counting.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        max_d  = max_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        tick_d = '0;
        done_d = done_q;
        flag_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            // Toggle mode keeps its level between terminal counts; the others return to 0.
            flag_d[i] = (mode_q[i] == MODE_TOGGLE) ? flag_q[i] : 1'b0;
            if (cfg_hit[i]) begin
                max_d[i]  = cfg_max;
                mode_d[i] = mode_e'(cfg_mode);
                cnt_d[i]  = '0;
                flag_d[i] = 1'b0;
                done_d[i] = 1'b0;
            end else if (counting[i]) begin
                if (cnt_q[i] == last_cnt[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    case (mode_q[i])
                        MODE_TOGGLE:  flag_d[i] = ~flag_q[i];
                        MODE_ONESHOT: begin
                            flag_d[i] = 1'b1;
                            done_d[i] = 1'b1;
                        end
                        default:      flag_d[i] = 1'b1;
                    endcase
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
        if (reset) begin
            // NOTE: the per-channel config arrays are reset explicitly because reset must restore DEFAULT_MAX.
            for (int i = 0; i < CHANNELS; i++) begin
                max_q[i]  <= DEFAULT_MAX;
                mode_q[i] <= MODE_TOGGLE;
                cnt_q[i]  <= '0;
            end
            flag_q <= '0;
            tick_q <= '0;
            done_q <= '0;
        end else begin
            max_q  <= max_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign flag = flag_q;
    assign tick = tick_q;
    assign done = done_q;

endmodule

// File: tb/tb_clock_gen_multi.sv
// tb_clock_gen_multi: directed and randomized bench for clock_gen_multi.
// A 4-channel and a 3-channel instance share stimulus; a model that counts
// "counting cycles since arm" per channel predicts every output each cycle.
module tb_clock_gen_multi;

    localparam int CW  = 16;
    localparam int DEF = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [3:0]    ch_enable;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [CW-1:0] cfg_max;
    logic [1:0]    cfg_mode;
    logic [3:0]    flag_a, tick_a, done_a;
    logic [2:0]    flag_b, tick_b, done_b;

    int total = 0;
    int bad   = 0;

    clock_gen_multi #(
        .CHANNELS(4), .CH_SEL_WIDTH(2), .CNT_WIDTH(CW), .DEFAULT_MAX(CW'(DEF))
    ) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .ch_enable(ch_enable),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
        .flag(flag_a), .tick(tick_a), .done(done_a)
    );

    clock_gen_multi #(
        .CHANNELS(3), .CH_SEL_WIDTH(2), .CNT_WIDTH(CW), .DEFAULT_MAX(CW'(DEF))
    ) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .ch_enable(ch_enable[2:0]),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_max(cfg_max), .cfg_mode(cfg_mode),
        .flag(flag_b), .tick(tick_b), .done(done_b)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state, index [dut][channel]: effective terminal count, mode,
    // number of counting cycles since the last arm, and whether the last edge ticked.
    int m_meff [2][4];
    int m_mode [2][4];
    int m_cnt  [2][4];
    bit m_tick [2][4];
    bit m_valid = 1'b0;
    bit halted, adv;
    int nc;

    // Reference model: advance each channel's counted-cycle total on every edge.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) begin
                if (i < ((d == 0) ? 4 : 3)) begin
                    if (reset) begin
                        m_meff[d][i] <= DEF;
                        m_mode[d][i] <= 0;
                        m_cnt[d][i]  <= 0;
                        m_tick[d][i] <= 1'b0;
                    end else if (m_valid) begin
                        if (cfg_we && int'(cfg_ch) == i) begin
                            m_meff[d][i] <= (cfg_max == '0) ? 1 : int'(cfg_max);
                            m_mode[d][i] <= int'(cfg_mode);
                            m_cnt[d][i]  <= 0;
                            m_tick[d][i] <= 1'b0;
                        end else begin
                            halted = (m_mode[d][i] == 2) && (m_cnt[d][i] >= m_meff[d][i]);
                            adv    = enable && ch_enable[i] && !halted;
                            nc     = m_cnt[d][i] + (adv ? 1 : 0);
                            m_cnt[d][i]  <= nc;
                            m_tick[d][i] <= adv && (nc % m_meff[d][i] == 0);
                        end
                    end
                end
            end
        end
        if (reset) m_valid <= 1'b1;
    end

    // kind 0 = flag, 1 = tick, 2 = done
    function automatic logic [3:0] exp_vec(input int d, input int kind);
        logic [3:0] v;
        v = '0;
        for (int i = 0; i < ((d == 0) ? 4 : 3); i++) begin
            case (kind)
                0: v[i] = (m_mode[d][i] == 0) ? ((m_cnt[d][i] / m_meff[d][i]) % 2 == 1) : m_tick[d][i];
                1: v[i] = m_tick[d][i];
                default: v[i] = (m_mode[d][i] == 2) && (m_cnt[d][i] >= m_meff[d][i]);
            endcase
        end
        return v;
    endfunction

    // Compare every output of both instances against the model once per cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_flag_a", 32'(flag_a), 32'(exp_vec(0, 0)));
            check("model_tick_a", 32'(tick_a), 32'(exp_vec(0, 1)));
            check("model_done_a", 32'(done_a), 32'(exp_vec(0, 2)));
            check("model_flag_b", 32'(flag_b), 32'(exp_vec(1, 0)[2:0]));
            check("model_tick_b", 32'(tick_b), 32'(exp_vec(1, 1)[2:0]));
            check("model_done_b", 32'(done_b), 32'(exp_vec(1, 2)[2:0]));
        end
    end

    // One-cycle configuration write; returns at the negedge after the sampling edge.
    task automatic write(input int ch, input int mx, input int md);
        cfg_we   = 1'b1;
        cfg_ch   = 2'(ch);
        cfg_max  = CW'(mx);
        cfg_mode = 2'(md);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        reset = 1'b1; enable = 1'b0; ch_enable = '0;
        cfg_we = 1'b0; cfg_ch = '0; cfg_max = '0; cfg_mode = '0;
        repeat (2) @(negedge clk);
        check("rst_flag", 32'(flag_a), 32'h0);
        check("rst_tick", 32'(tick_a), 32'h0);
        check("rst_done", 32'(done_a), 32'h0);

        // Default terminal count 5 on all channels, toggle mode.
        reset = 1'b0; enable = 1'b1; ch_enable = 4'hF;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            check("def_tick_a", 32'(tick_a), (c % 5 == 0) ? 32'hF : 32'h0);
            check("def_flag_a", 32'(flag_a), ((c / 5) % 2 == 1) ? 32'hF : 32'h0);
            check("def_tick_b", 32'(tick_b), (c % 5 == 0) ? 32'h7 : 32'h0);
        end
        check("def_done", 32'(done_a), 32'h0);

        // ch1 M=3 pulse, ch2 M=0 toggle (every cycle).
        write(1, 3, 1);
        check("p_arm_tick1", 32'(tick_a[1]), 32'h0);
        check("p_arm_flag1", 32'(flag_a[1]), 32'h0);
        write(2, 0, 0);
        @(negedge clk);
        check("t0_flag2_c2", 32'(flag_a[2]), 32'h1);
        check("p_tick1_c2", 32'(tick_a[1]), 32'h0);
        @(negedge clk);
        check("p_tick1_c3", 32'(tick_a[1]), 32'h1);
        check("p_flag1_c3", 32'(flag_a[1]), 32'h1);
        check("t0_flag2_c3", 32'(flag_a[2]), 32'h0);
        for (int c = 4; c <= 9; c++) begin
            @(negedge clk);
            check("p_tick1", 32'(tick_a[1]), (c % 3 == 0) ? 32'h1 : 32'h0);
            check("p_flag1", 32'(flag_a[1]), (c % 3 == 0) ? 32'h1 : 32'h0);
            check("t0_flag2", 32'(flag_a[2]), 32'((c - 1) % 2));
        end

        // ch3 M=4 one-shot, then re-arm.
        write(3, 4, 2);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            check("os_tick3", 32'(tick_a[3]), (c == 4) ? 32'h1 : 32'h0);
            check("os_flag3", 32'(flag_a[3]), (c == 4) ? 32'h1 : 32'h0);
            check("os_done3", 32'(done_a[3]), (c >= 4) ? 32'h1 : 32'h0);
        end
        write(3, 4, 2);
        check("os_rearm_done3", 32'(done_a[3]), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("os_rearm_tick3", 32'(tick_a[3]), (c == 4) ? 32'h1 : 32'h0);
        end

        // ch0 M=6 toggle, enable dropped for 3 cycles at count 2.
        write(0, 6, 0);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk);
            check("hold_tick0", 32'(tick_a[0]), 32'h0);
            check("hold_flag0", 32'(flag_a[0]), 32'h0);
        end
        enable = 1'b1;
        for (int c = 6; c <= 9; c++) begin
            @(negedge clk);
            check("hold_resume_tick0", 32'(tick_a[0]), (c == 9) ? 32'h1 : 32'h0);
            check("hold_resume_flag0", 32'(flag_a[0]), (c == 9) ? 32'h1 : 32'h0);
        end

        // Write on the terminal-count cycle suppresses the tick and restarts.
        write(0, 4, 0);
        repeat (3) @(negedge clk);
        write(0, 4, 0);
        check("cfg_prio_tick0", 32'(tick_a[0]), 32'h0);
        check("cfg_prio_flag0", 32'(flag_a[0]), 32'h0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("cfg_prio_restart0", 32'(tick_a[0]), (c == 4) ? 32'h1 : 32'h0);
        end

        // Reset mid-count, then check the default count is back and ch3 writes miss dut_b.
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_out_a", 32'({flag_a, tick_a, done_a}), 32'h0);
        check("mid_rst_out_b", 32'({flag_b, tick_b, done_b}), 32'h0);
        reset = 1'b0;
        write(3, 1, 1);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            check("post_rst_tick_b", 32'(tick_b), (c == 5) ? 32'h7 : 32'h0);
            check("post_rst_tick_a", 32'(tick_a[2:0]), (c == 5) ? 32'h7 : 32'h0);
            check("post_rst_tick_a3", 32'(tick_a[3]), 32'h1);
        end

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(399) == 0);
            enable    = ($urandom_range(9) != 0);
            ch_enable = 4'($urandom_range(15));
            cfg_we    = ($urandom_range(11) == 0);
            cfg_ch    = 2'($urandom_range(3));
            cfg_max   = CW'($urandom_range(9));
            cfg_mode  = 2'($urandom_range(3));
            @(negedge clk);
        end
        reset = 1'b0; cfg_we = 1'b0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
